// File: rtl/regfile_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_rd_arbiter
//  Purpose  : Round-robin arbiter sharing one register-file read port among
//             NREQ requesters. Issues at most one grant per cycle, drives the
//             read-port select from a register and returns the captured read
//             data to the winner one cycle after its grant.
//  Ports    :
//    clk        in   clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    req        in   [NREQ]     per-requester request, held until gnt
//    req_addr   in   [NREQ*AW]  packed indices, requester i at [i*AW +: AW]
//    gnt        out  [NREQ]     registered one-hot grant pulse
//    mux_sel    out  [AW]       registered read-port select
//    mux_data   in   [DW]       combinational read-port data for mux_sel
//    rsp_valid  out  [NREQ]     registered one-hot response-valid pulse
//    rsp_data   out  [DW]       registered read data
//  Revision : 1.0  initial release
// ============================================================================
module regfile_rd_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    gnt,
    output logic [AW-1:0]      mux_sel,
    input  logic [DW-1:0]      mux_data,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data
);

    localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NREQ-1:0] gnt_q,       gnt_d;
    logic [AW-1:0]   mux_sel_q,   mux_sel_d;
    logic [IW-1:0]   last_q,      last_d;
    logic            s1_valid_q,  s1_valid_d;
    logic [IW-1:0]   s1_id_q,     s1_id_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q,  rsp_data_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NREQ-1:0] eligible;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic [AW-1:0]   win_addr;

    always_comb begin
        // A requester whose grant is visible this cycle is still holding
        // req; masking it here keeps one request from winning twice.
        eligible  = req & ~gnt_q;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        // Scan last+1, last+2, ... wrapping; the first eligible index wins.
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_addr = req_addr[int'(win_idx)*AW +: AW];
    end

    // ------------------------------------------------------------------
    // Next-state: issue stage and capture stage
    // ------------------------------------------------------------------
    always_comb begin
        gnt_d       = '0;
        mux_sel_d   = mux_sel_q;
        last_d      = last_q;
        s1_valid_d  = 1'b0;
        s1_id_d     = s1_id_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;

        if (win_found) begin
            gnt_d      = ONE_HOT0 << win_idx;
            mux_sel_d  = win_addr;
            last_d     = win_idx;
            s1_valid_d = 1'b1;
            s1_id_d    = win_idx;
        end

        // mux_sel still holds the winner's index during this cycle, so the
        // read port is presenting that winner's data right now.
        if (s1_valid_q) begin
            rsp_valid_d = ONE_HOT0 << s1_id_q;
            rsp_data_d  = mux_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            mux_sel_q   <= '0;
            last_q      <= LAST_RST;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            gnt_q       <= gnt_d;
            mux_sel_q   <= mux_sel_d;
            last_q      <= last_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign mux_sel   = mux_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_rd_arbiter
//  Purpose  : Self-checking bench for regfile_rd_arbiter. Directed stimulus
//             pushes expected grants and responses into queues; a monitor
//             pops and compares whenever gnt or rsp_valid is nonzero.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_rd_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 4;
    localparam int DW   = 32;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    gnt;
    logic [AW-1:0]      mux_sel;
    logic [DW-1:0]      mux_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    logic [NREQ-1:0]      exp_gnt_q[$];
    logic [NREQ+DW-1:0]   exp_rsp_q[$];

    regfile_rd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .mux_sel   (mux_sel),
        .mux_data  (mux_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register-file contents: every entry distinct, R5 fixed.
    function automatic logic [31:0] rf_val(input logic [3:0] a);
        if (a == 4'd5) return 32'hDEAD_BEEF;
        return {4'hC, a, 8'h3A, 4'h0, a, 4'h7, a};
    endfunction

    assign mux_data = rf_val(mux_sel);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic expect_txn(input int id, input logic [3:0] addr);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << id;
        exp_gnt_q.push_back(oh);
        exp_rsp_q.push_back({oh, rf_val(addr)});
    endtask

    task automatic set_addr(input int id, input logic [3:0] addr);
        req_addr[id*AW +: AW] = addr;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [NREQ-1:0]    eg;
        logic [NREQ+DW-1:0] er;
        if (mon_en && rst_n) begin
            if (gnt != '0) begin
                checks++;
                if (exp_gnt_q.size() == 0) begin
                    errors++;
                    $display("FAIL gnt_unexpected: got %b, expected no grant", gnt);
                end else begin
                    eg = exp_gnt_q.pop_front();
                    if (gnt !== eg) begin
                        errors++;
                        $display("FAIL gnt_order: got %b, expected %b", gnt, eg);
                    end
                end
            end
            if (rsp_valid != '0) begin
                checks++;
                if (exp_rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got valid %b data %h, expected none", rsp_valid, rsp_data);
                end else begin
                    er = exp_rsp_q.pop_front();
                    if ({rsp_valid, rsp_data} !== er) begin
                        errors++;
                        $display("FAIL rsp: got valid %b data %h, expected valid %b data %h",
                                 rsp_valid, rsp_data, er[NREQ+DW-1:DW], er[DW-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] phase [NREQ];
        int         ngnt;

        rst_n    = 1'b1;
        req      = '0;
        req_addr = '0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset_gnt",       32'(gnt),       32'h0);
        check("reset_mux_sel",   32'(mux_sel),   32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_data",  rsp_data,       32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single request from requester 0, R5.
        @(posedge clk); #1;
        set_addr(0, 4'd5);
        req = 4'b0001;
        expect_txn(0, 4'd5);
        @(posedge clk); #1;
        req = '0;
        check("single_mux_sel", 32'(mux_sel), 32'd5);
        repeat (4) @(posedge clk);

        // Round-robin with drop/re-raise requesters.
        reset_dut();
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            set_addr(i, 4'(i + 1));
            phase[i] = 2'd0;
        end
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < NREQ; i++) expect_txn(i, 4'(i + 1));
        req  = 4'b1111;
        ngnt = 0;
        for (int cyc = 0; cyc < 60 && ngnt < 8; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    ngnt++;
                    phase[i] = 2'd1;
                end else if (phase[i] == 2'd1) begin
                    req[i]   = 1'b0;
                    phase[i] = 2'd2;
                end else if (phase[i] == 2'd2) begin
                    req[i]   = 1'b1;
                    phase[i] = 2'd0;
                end
            end
            if (ngnt >= 8) req = '0;
        end
        req = '0;
        check("rr_grant_count", 32'(ngnt), 32'd8);
        repeat (4) @(posedge clk);

        // Held request: grants on alternate cycles only.
        reset_dut();
        @(posedge clk); #1;
        set_addr(2, 4'd15);
        req = 4'b0100;
        for (int n = 0; n < 3; n++) expect_txn(2, 4'd15);
        repeat (5) @(posedge clk);
        #1 req = '0;
        repeat (4) @(posedge clk);

        // Wrap-around from last=3.
        reset_dut();
        @(posedge clk); #1;
        set_addr(0, 4'd6);
        set_addr(3, 4'd7);
        req = 4'b1001;
        expect_txn(0, 4'd6);
        expect_txn(3, 4'd7);
        @(posedge clk); #1 req[0] = 1'b0;
        @(posedge clk); #1 req[3] = 1'b0;
        @(posedge clk); #1;
        set_addr(3, 4'd8);
        req = 4'b1000;
        expect_txn(3, 4'd8);
        @(posedge clk); #1 req = '0;
        repeat (4) @(posedge clk);

        // Idle hold of mux_sel.
        reset_dut();
        @(posedge clk); #1;
        set_addr(1, 4'd9);
        req = 4'b0010;
        expect_txn(1, 4'd9);
        @(posedge clk); #1 req = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_mux_sel", 32'(mux_sel), 32'd9);
            check("idle_gnt",     32'(gnt),     32'h0);
            if (k == 1) check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        end

        // Reset while a grant is in flight.
        reset_dut();
        @(posedge clk); #1;
        set_addr(0, 4'd2);
        req = 4'b0001;
        exp_gnt_q.push_back(4'b0001);
        @(posedge clk); #1 req = '0;
        @(negedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("flush_rsp_valid", 32'(rsp_valid), 32'h0);
        end
        // last must be 3 again: requester 0 wins before requester 3.
        @(posedge clk); #1;
        set_addr(0, 4'd3);
        set_addr(3, 4'd4);
        req = 4'b1001;
        expect_txn(0, 4'd3);
        expect_txn(3, 4'd4);
        @(posedge clk); #1 req[0] = 1'b0;
        @(posedge clk); #1 req[3] = 1'b0;

        // Drain with a bounded wait.
        for (int k = 0; k < 20 && (exp_gnt_q.size() != 0 || exp_rsp_q.size() != 0); k++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        check("drain_gnt_queue", 32'(exp_gnt_q.size()), 32'd0);
        check("drain_rsp_queue", 32'(exp_rsp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
